alu_exec_ctrl: RTL and testbench
================================

ALU_EXEC_CTRL -- requirements
Module: alu_exec_ctrl

Interface
REQ-001: Parameters: none; datapath width is fixed at 4 bits and the register count at 4.
REQ-002: Clock  input  1  single clock; all state updates on its rising edge.
REQ-003: Resetn  input  1  asynchronous, active-low reset.
REQ-004: InValid  input  1  instruction offered on Instr this cycle.
REQ-005: InReady  output  1  block accepts an instruction this cycle.
REQ-006: Instr  input  9  bit8 LDI flag; ALU form: [7:6] Op, [5:4] Rd, [3:2] Rs, [1:0] ignored; LDI form: [5:4] Rd, [3:0] Imm, [7:6] ignored.
REQ-007: A  output  4  ALU operand A (downstream ALU data input).
REQ-008: B  output  4  ALU operand B.
REQ-009: S  output  2  ALU function select: 00 add, 01 subtract, 10 AND, 11 XOR.
REQ-010: R  input  4  ALU result.
REQ-011: Cout  input  1  ALU carry-out status.
REQ-012: OVR  input  1  ALU overflow status.
REQ-013: Done  output  1  one-cycle pulse marking instruction completion.
REQ-014: Z, C, V  output  1 each  registered zero, carry, overflow flags.
REQ-015: RdSel  input  2  register selected for display.
REQ-016: RegOut  output  4  combinational contents of register RdSel.

Function
REQ-017: Storage: four 4-bit registers R0-R3, instruction register IR (9 bits), flags Z/C/V.
REQ-018: FSM states IDLE, OPER, EXEC, DONE; InReady = 1 only in IDLE.
REQ-019: IDLE with InValid=1: IR <= Instr on the edge; ALU form -> OPER; LDI form -> DONE with Rd <= Imm and Z <= (Imm==0) on that same edge, C and V unchanged.
REQ-020: IDLE with InValid=0: remain in IDLE, no state change.
REQ-021: OPER and EXEC: A = reg[IR.Rd], B = reg[IR.Rs], S = IR.Op, held constant across both cycles; OPER -> EXEC unconditionally.
REQ-022: Outside OPER/EXEC: A = 0, B = 0, S = 00.
REQ-023: Edge leaving EXEC: reg[Rd] <= R, Z <= (R==0), C <= Cout, V <= OVR; EXEC -> DONE.
REQ-024: DONE: Done = 1, no register or flag writes; DONE -> IDLE.
REQ-025: Latency: ALU instruction accepted at edge k completes with Done high in cycle k+3; LDI has Done high in cycle k+1; maximum throughput is one ALU instruction per 4 cycles, one LDI per 2 cycles.
REQ-026: Rd == Rs is legal; both operands read the same pre-write value.
REQ-027: InValid while not in IDLE is ignored and the offered Instr is not captured; the source must hold it until InReady=1.
REQ-028: Flags are written only at the REQ-019 and REQ-023 edges; no other event modifies them.
REQ-029: RegOut reflects a register write in the cycle after the writing edge.

Reset
REQ-030: Resetn=0 forces, asynchronously, FSM = IDLE, R0-R3 = 0, IR = 0, Z = C = V = 0, Done = 0, A = B = 0, S = 00.
REQ-031: Reset during OPER/EXEC/DONE aborts the instruction with no register write; InReady = 1 in the first cycle after release.

Verification
REQ-032: Reset; LDI R0=5 (Instr=1_00_00_0101), then LDI R1=3 -> Done pulses for 1 cycle each; RegOut(RdSel=0)=5, RegOut(RdSel=1)=3; Z=0.
REQ-033: ALU ADD Rd=R0, Rs=R1 -> A=5, B=3, S=00 during OPER and EXEC; with ALU returning R=8 -> R0=8, C=0, V=1, Z=0, Done in cycle k+3.
REQ-034: SUB Rd=R1, Rs=R1 (value 3) -> A=B=3, S=01; R1=0, Z=1, C equals the ALU Cout (1 for the ripple-carry subtractor), V=0.
REQ-035: InValid held high with a new instruction during OPER/EXEC/DONE -> InReady=0, no capture; the instruction is captured on the first IDLE edge; back-to-back ALU ops are accepted exactly 4 cycles apart.
REQ-036: Resetn pulsed low during EXEC of ADD R2,R3 -> no write to R2, all registers and flags 0, Done never pulses, InReady=1 after release.
REQ-037: LDI R3=0 after an ADD that set C=1, V=1 -> Z=1, C=1, V=1 retained.

Source files
------------

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl
//   Sequencer for a 4-bit external ALU backed by a 4 x 4-bit register file.
//   It accepts one 9-bit instruction at a time through a valid/ready handshake.
//     LDI form (Instr[8]=1): Rd <= Imm, Z <= (Imm==0). This completes in 2 cycles.
//     ALU form (Instr[8]=0): the operands are presented on A/B and the function
//       code on S for two cycles. The result and status are then written back.
//       This completes in 4 cycles.
//
// Ports
//   Clock   : single clock, rising-edge active
//   Resetn  : asynchronous active-low reset
//   InValid : instruction offered on Instr
//   InReady : block accepts an instruction this cycle (IDLE only)
//   Instr   : [8] LDI flag, [7:6] Op, [5:4] Rd, [3:2] Rs / [3:0] Imm
//   A, B, S : operands and function select driven to the external ALU
//   R       : ALU result; Cout / OVR : ALU carry-out / overflow status
//   Done    : one-cycle completion pulse
//   Z, C, V : registered zero / carry / overflow flags
//   RdSel   : register selected for display; RegOut : its contents
module alu_exec_ctrl (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       InValid,
  output logic       InReady,
  input  logic [8:0] Instr,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic [1:0] S,
  input  logic [3:0] R,
  input  logic       Cout,
  input  logic       OVR,
  output logic       Done,
  output logic       Z,
  output logic       C,
  output logic       V,
  input  logic [1:0] RdSel,
  output logic [3:0] RegOut
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPER = 2'd1,
    EXEC = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic [3:0] regs [4];
  logic [8:0] ir;
  logic       z_q;
  logic       c_q;
  logic       v_q;

  // Field views of the incoming and the captured instruction
  logic       in_ldi;
  logic [1:0] in_rd;
  logic [3:0] in_imm;
  logic [1:0] ir_op;
  logic [1:0] ir_rd;
  logic [1:0] ir_rs;

  assign in_ldi = Instr[8];
  assign in_rd  = Instr[5:4];
  assign in_imm = Instr[3:0];
  assign ir_op  = ir[7:6];
  assign ir_rd  = ir[5:4];
  assign ir_rs  = ir[3:2];

  // Write-port controls shared by the LDI and ALU write-back paths
  logic       accept;
  logic       reg_we;
  logic [1:0] reg_wa;
  logic [3:0] reg_wd;
  logic       z_we;
  logic       z_d;
  logic       cv_we;

  // State register
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and the state-decoded outputs
  always_comb begin
    state_nxt = state;
    InReady   = 1'b0;
    Done      = 1'b0;
    A         = '0;
    B         = '0;
    S         = '0;
    case (state)
      IDLE: begin
        InReady = 1'b1;
        if (InValid) begin
          state_nxt = in_ldi ? DONE : OPER;
        end
      end
      OPER: begin
        A         = regs[ir_rd];
        B         = regs[ir_rs];
        S         = ir_op;
        state_nxt = EXEC;
      end
      EXEC: begin
        A         = regs[ir_rd];
        B         = regs[ir_rs];
        S         = ir_op;
        state_nxt = DONE;
      end
      DONE: begin
        Done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Write-port steering. LDI writes on the accepting edge. An ALU op writes
  // on the edge leaving EXEC. No other edge touches the registers or flags.
  always_comb begin
    accept = (state == IDLE) && InValid;
    reg_we = 1'b0;
    reg_wa = '0;
    reg_wd = '0;
    z_we   = 1'b0;
    z_d    = 1'b0;
    cv_we  = 1'b0;
    if (accept && in_ldi) begin
      reg_we = 1'b1;
      reg_wa = in_rd;
      reg_wd = in_imm;
      z_we   = 1'b1;
      z_d    = (in_imm == 4'd0);
    end else if (state == EXEC) begin
      reg_we = 1'b1;
      reg_wa = ir_rd;
      reg_wd = R;
      z_we   = 1'b1;
      z_d    = (R == 4'd0);
      cv_we  = 1'b1;
    end
  end

  // Register file, instruction register and flags
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      regs <= '{default: '0};
      ir   <= '0;
      z_q  <= 1'b0;
      c_q  <= 1'b0;
      v_q  <= 1'b0;
    end else begin
      if (accept) begin
        ir <= Instr;
      end
      if (reg_we) begin
        regs[reg_wa] <= reg_wd;
      end
      if (z_we) begin
        z_q <= z_d;
      end
      if (cv_we) begin
        c_q <= Cout;
        v_q <= OVR;
      end
    end
  end

  assign Z      = z_q;
  assign C      = c_q;
  assign V      = v_q;
  assign RegOut = regs[RdSel];

endmodule

// File: tb/tb_alu_exec_ctrl.sv
module tb_alu_exec_ctrl;

  logic       Clock;
  logic       Resetn;
  logic       InValid;
  logic       InReady;
  logic [8:0] Instr;
  logic [3:0] A;
  logic [3:0] B;
  logic [1:0] S;
  logic [3:0] R;
  logic       Cout;
  logic       OVR;
  logic       Done;
  logic       Z;
  logic       C;
  logic       V;
  logic [1:0] RdSel;
  logic [3:0] RegOut;

  int total = 0;
  int bad   = 0;

  // Architectural reference state
  int mreg [4];
  int mz, mc, mv;

  alu_exec_ctrl dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .InValid(InValid),
    .InReady(InReady),
    .Instr  (Instr),
    .A      (A),
    .B      (B),
    .S      (S),
    .R      (R),
    .Cout   (Cout),
    .OVR    (OVR),
    .Done   (Done),
    .Z      (Z),
    .C      (C),
    .V      (V),
    .RdSel  (RdSel),
    .RegOut (RegOut)
  );

  initial Clock = 1'b0;
  always #10 Clock = ~Clock;

  task automatic chk(input string tag, input logic [8:0] obs, input int exp);
    total++;
    assert (obs === 9'(exp)) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // 4-bit ripple ALU: subtract is A + ~B + 1, V is two's-complement overflow
  function automatic void alu_ref(input int op, input int a, input int b,
                                  output int r, output int co, output int ov);
    int s;
    int sa, sb, sr;
    co = 0;
    ov = 0;
    case (op)
      0: begin s = a + b;            r = s % 16; co = s / 16; end
      1: begin s = a + (15 - b) + 1; r = s % 16; co = s / 16; end
      2: r = a & b;
      default: r = a ^ b;
    endcase
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    sr = (op == 0) ? sa + sb : sa - sb;
    if (op < 2 && (sr > 7 || sr < -8)) ov = 1;
  endfunction

  task automatic chk_state(input string tag);
    for (int i = 0; i < 4; i++) begin
      RdSel = 2'(i);
      #1;
      chk($sformatf("%s_reg%0d", tag, i), 9'(RegOut), mreg[i]);
    end
    chk({tag, "_Z"}, 9'(Z), mz);
    chk({tag, "_C"}, 9'(C), mc);
    chk({tag, "_V"}, 9'(V), mv);
  endtask

  // While busy, sometimes offer a random instruction that must be ignored
  task automatic junk_busy();
    InValid = 1'($urandom);
    Instr   = 9'($urandom);
    R       = 4'($urandom);
    Cout    = 1'($urandom);
    OVR     = 1'($urandom);
  endtask

  task automatic ldi(input int rd, input int imm);
    chk("ldi_ready", 9'(InReady), 1);
    InValid = 1'b1;
    Instr   = {1'b1, 2'($urandom), 2'(rd), 4'(imm)};
    tick();
    mreg[rd] = imm;
    mz       = (imm == 0) ? 1 : 0;
    junk_busy();
    chk("ldi_done", 9'(Done), 1);
    chk("ldi_busy", 9'(InReady), 0);
    chk("ldi_A", 9'(A), 0);
    chk("ldi_B", 9'(B), 0);
    chk("ldi_S", 9'(S), 0);
    chk_state("ldi");
    tick();
    InValid = 1'b0;
    chk("ldi_done_end", 9'(Done), 0);
    chk("ldi_ready_end", 9'(InReady), 1);
  endtask

  task automatic alu(input int op, input int rd, input int rs);
    int a, b, r, co, ov;
    a = mreg[rd];
    b = mreg[rs];
    alu_ref(op, a, b, r, co, ov);
    chk("alu_ready", 9'(InReady), 1);
    InValid = 1'b1;
    Instr   = {1'b0, 2'(op), 2'(rd), 2'(rs), 2'($urandom)};
    tick();
    for (int k = 0; k < 2; k++) begin
      junk_busy();
      R    = 4'(r);
      Cout = 1'(co);
      OVR  = 1'(ov);
      chk($sformatf("alu_A_c%0d", k + 1), 9'(A), a);
      chk($sformatf("alu_B_c%0d", k + 1), 9'(B), b);
      chk($sformatf("alu_S_c%0d", k + 1), 9'(S), op);
      chk($sformatf("alu_done_c%0d", k + 1), 9'(Done), 0);
      chk($sformatf("alu_busy_c%0d", k + 1), 9'(InReady), 0);
      chk_state($sformatf("alu_pre_c%0d", k + 1));
      tick();
    end
    mreg[rd] = r;
    mz       = (r == 0) ? 1 : 0;
    mc       = co;
    mv       = ov;
    junk_busy();
    chk("alu_done_k3", 9'(Done), 1);
    chk("alu_busy_k3", 9'(InReady), 0);
    chk("alu_A_done", 9'(A), 0);
    chk("alu_S_done", 9'(S), 0);
    chk_state("alu_wb");
    tick();
    InValid = 1'b0;
    chk("alu_done_end", 9'(Done), 0);
    chk("alu_ready_end", 9'(InReady), 1);
    chk_state("alu_after");
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mreg[i] = 0;
    mz = 0;
    mc = 0;
    mv = 0;
  endtask

  initial begin
    Resetn  = 1'b1;
    InValid = 1'b0;
    Instr   = '0;
    R       = '0;
    Cout    = 1'b0;
    OVR     = 1'b0;
    RdSel   = '0;
    model_reset();

    // Reset state
    #2 Resetn = 1'b0;
    #2;
    chk("rst_ready", 9'(InReady), 1);
    chk("rst_done", 9'(Done), 0);
    chk("rst_A", 9'(A), 0);
    chk("rst_B", 9'(B), 0);
    chk("rst_S", 9'(S), 0);
    chk_state("rst");
    tick();
    Resetn = 1'b1;

    // Idle without InValid: nothing changes
    for (int k = 0; k < 3; k++) begin
      R = 4'($urandom); Cout = 1'b1; OVR = 1'b1;
      tick();
      chk("idle_ready", 9'(InReady), 1);
      chk("idle_done", 9'(Done), 0);
    end
    chk_state("idle");

    // Directed program
    ldi(0, 5);
    ldi(1, 3);
    alu(0, 0, 1);     // ADD R0,R1: 5+3 = 8, C=0, V=1
    alu(1, 1, 1);     // SUB R1,R1: 0, Z=1, C=1, V=0
    ldi(2, 8);
    ldi(3, 8);
    alu(0, 2, 3);     // 8+8: R=0, Z=1, C=1, V=1
    ldi(3, 0);        // Z=1, C/V retained
    ldi(3, 7);        // Z=0, C/V retained
    alu(2, 3, 0);
    alu(3, 0, 3);

    // Random mix
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0)
        ldi(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
      else
        alu(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)));
    end

    // Reset in EXEC of ADD R2,R3 aborts the write
    ldi(2, 9);
    ldi(3, 6);
    InValid = 1'b1;
    Instr   = {1'b0, 2'd0, 2'd2, 2'd3, 2'd0};
    tick();
    InValid = 1'b0;
    tick();
    chk("abort_in_exec_S", 9'(S), 0);
    chk("abort_in_exec_A", 9'(A), 9);
    R = 4'd15; Cout = 1'b1; OVR = 1'b1;
    #1 Resetn = 1'b0;
    #1;
    model_reset();
    chk("abort_ready", 9'(InReady), 1);
    chk("abort_done", 9'(Done), 0);
    chk("abort_A", 9'(A), 0);
    chk("abort_B", 9'(B), 0);
    chk_state("abort");
    tick();
    Resetn = 1'b1;
    chk("abort_ready_rel", 9'(InReady), 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("abort_no_done", 9'(Done), 0);
      chk("abort_still_ready", 9'(InReady), 1);
    end
    chk_state("abort_after");

    // Normal operation after reset
    ldi(1, 12);
    ldi(2, 4);
    alu(0, 1, 2);     // 12+4: R=0, C=1, V=0
    alu(1, 2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Whole-run time limit
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
